// File: rtl/adc_tap_if.sv
// Sample stream from the SPI ADC controller plus the timestamped event drain port.
interface adc_tap_if;
    logic [9:0]  ch0_word;
    logic [9:0]  ch1_word;
    logic        valid;
    logic        evt_valid;
    logic        evt_ready;
    logic        evt_ch;
    logic [15:0] evt_time;

    modport master (
        output ch0_word, ch1_word, valid, evt_ready,
        input  evt_valid, evt_ch, evt_time
    );

    modport slave (
        input  ch0_word, ch1_word, valid, evt_ready,
        output evt_valid, evt_ch, evt_time
    );
endinterface

// File: rtl/adc_tap_detector.sv
// Two-channel EMA smoother with hysteresis threshold, per-channel holdoff and a
// show-ahead FIFO of timestamped rising-crossing events.
module adc_tap_detector #(
    parameter int SHIFT      = 3,
    parameter int TH_HI      = 600,
    parameter int TH_LO      = 400,
    parameter int HOLDOFF    = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    adc_tap_if.slave   bus,
    output logic [9:0] level0_o,
    output logic [9:0] level1_o,
    output logic       above0_o,
    output logic       above1_o,
    output logic       overrun_o,
    output logic       dropped_o
);
    localparam int AW = 10 + SHIFT;
    localparam int HW = (HOLDOFF > 0) ? $clog2(HOLDOFF + 1) : 1;
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam logic [9:0]    TH_HI_L = 10'(TH_HI);
    localparam logic [9:0]    TH_LO_L = 10'(TH_LO);
    localparam logic [HW-1:0] HOLD_L  = HW'(HOLDOFF);
    localparam logic [PW:0]   DEPTH_L = (PW + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, CH0, CH1} state_t;

    state_t      state_q;
    logic [9:0]  word_q [2];
    logic [15:0] sample_cnt_q;
    logic [15:0] ts_q;
    logic        overrun_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            word_q[0]    <= '0;
            word_q[1]    <= '0;
            sample_cnt_q <= '0;
            ts_q         <= '0;
            overrun_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.valid) begin
                        word_q[0]    <= bus.ch0_word;
                        word_q[1]    <= bus.ch1_word;
                        ts_q         <= sample_cnt_q;
                        sample_cnt_q <= sample_cnt_q + 16'd1;
                        state_q      <= CH0;
                    end
                end
                CH0: begin
                    state_q <= CH1;
                    if (bus.valid) overrun_q <= 1'b1;
                end
                CH1: begin
                    state_q <= IDLE;
                    if (bus.valid) overrun_q <= 1'b1;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    logic [1:0] fire;
    logic [9:0] level_w [2];
    logic [1:0] above_w;

    for (genvar gi = 0; gi < 2; gi++) begin : g_ch
        logic [AW-1:0] acc_q;
        logic [AW-1:0] acc_d;
        logic [9:0]    level_q;
        logic [9:0]    level_d;
        logic          above_q;
        logic [HW-1:0] hold_q;
        logic          proc;
        logic          rise;

        assign proc    = (gi == 0) ? (state_q == CH0) : (state_q == CH1);
        // Modular wrap of the intermediate sum is harmless: the final value fits.
        assign acc_d   = acc_q + AW'(word_q[gi]) - (acc_q >> SHIFT);
        assign level_d = acc_d[SHIFT +: 10];
        assign rise    = !above_q && (level_d >= TH_HI_L);
        assign fire[gi] = proc && rise && (hold_q == '0);

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                acc_q   <= '0;
                level_q <= '0;
                above_q <= 1'b0;
                hold_q  <= '0;
            end else if (proc) begin
                acc_q   <= acc_d;
                level_q <= level_d;
                if (rise)
                    above_q <= 1'b1;
                else if (above_q && (level_d <= TH_LO_L))
                    above_q <= 1'b0;
                // Holdoff reloads on every emitted crossing, even if the FIFO drops it.
                if (fire[gi])
                    hold_q <= HOLD_L;
                else if (hold_q != '0)
                    hold_q <= hold_q - HW'(1);
            end
        end

        assign level_w[gi] = level_q;
        assign above_w[gi] = above_q;
    end

    assign level0_o  = level_w[0];
    assign level1_o  = level_w[1];
    assign above0_o  = above_w[0];
    assign above1_o  = above_w[1];
    assign overrun_o = overrun_q;

    logic [16:0]   mem_q [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_q;
    logic [PW-1:0] rd_ptr_q;
    logic [PW:0]   count_q;
    logic          dropped_q;
    logic          full;
    logic          empty;
    logic          push;
    logic          push_ok;
    logic          pop;

    assign full    = (count_q == DEPTH_L);
    assign empty   = (count_q == '0);
    assign push    = |fire;
    assign push_ok = push && !full;
    assign pop     = !empty && bus.evt_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            dropped_q <= 1'b0;
        end else begin
            if (push_ok) begin
                mem_q[wr_ptr_q] <= {fire[1], ts_q};
                wr_ptr_q        <= wr_ptr_q + PW'(1);
            end
            if (pop) rd_ptr_q <= rd_ptr_q + PW'(1);
            case ({push_ok, pop})
                2'b10:   count_q <= count_q + (PW + 1)'(1);
                2'b01:   count_q <= count_q - (PW + 1)'(1);
                default: count_q <= count_q;
            endcase
            if (push && full) dropped_q <= 1'b1;
        end
    end

    assign bus.evt_valid = !empty;
    assign bus.evt_ch    = mem_q[rd_ptr_q][16];
    assign bus.evt_time  = mem_q[rd_ptr_q][15:0];
    assign dropped_o     = dropped_q;
endmodule
